// File: rtl/sensor_conditioner.sv
// Synchronises, debounces and edge-detects the track sensors, then encodes rises into trip events.
// Optional sequence checking is enabled by defining SENSOR_ORDER_CHECK_EN.
module sensor_conditioner #(
    parameter int unsigned N_SENSORS = 6,
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SENSORS-1:0] s_raw,
    output logic [N_SENSORS-1:0] s_level,
    output logic [N_SENSORS-1:0] s_rise,
    output logic                 trip_valid,
    output logic [2:0]           trip_id,
    output logic                 multi_trip,
    output logic                 order_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [N_SENSORS-1:0] sync1_q, sync2_q;
    logic [CNT_W-1:0]     cnt_q [N_SENSORS];
    logic [CNT_W-1:0]     cnt_d [N_SENSORS];
    logic [N_SENSORS-1:0] level_q, level_d;
    logic [N_SENSORS-1:0] rise_q, rise_d;
    logic                 trip_valid_q, trip_valid_d;
    logic [2:0]           trip_id_q, trip_id_d;
    logic                 multi_q, multi_d;
    logic                 order_err_q, order_err_d;
    logic [2:0]           id_lo;

    // Debounce: a level flips only after DB_CYCLES consecutive differing samples
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        for (int i = 0; i < int'(N_SENSORS); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = ~level_q[i];
                    rise_d[i]  = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Trip encoder: lowest rising sensor wins, its 1-based index is reported
    always_comb begin
        id_lo = '0;
        for (int i = int'(N_SENSORS) - 1; i >= 0; i--) begin
            if (rise_q[i]) id_lo = 3'(i + 1);
        end
        trip_valid_d = |rise_q;
        trip_id_d    = trip_id_q;
        multi_d      = 1'b0;
        if (trip_valid_d) begin
            trip_id_d = id_lo;
            multi_d   = (rise_q & (rise_q - N_SENSORS'(1))) != '0;
        end
    end

`ifdef SENSOR_ORDER_CHECK_EN
    logic [2:0] last_id_q, last_id_d;
    logic [2:0] id_next, id_prev;

    // Each trip must be a neighbour of the previous one, wrapping at the ends
    always_comb begin
        id_next     = (last_id_q == 3'(N_SENSORS)) ? 3'd1 : last_id_q + 3'd1;
        id_prev     = (last_id_q == 3'd1) ? 3'(N_SENSORS) : last_id_q - 3'd1;
        last_id_d   = last_id_q;
        order_err_d = 1'b0;
        if (trip_valid_d) begin
            last_id_d   = id_lo;
            order_err_d = multi_d ||
                          ((last_id_q != 3'd0) && (id_lo != id_next) && (id_lo != id_prev));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_id_q <= '0;
        else     last_id_q <= last_id_d;
    end
`else
    assign order_err_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            rise_q       <= '0;
            trip_valid_q <= 1'b0;
            trip_id_q    <= '0;
            multi_q      <= 1'b0;
            order_err_q  <= 1'b0;
            for (int i = 0; i < int'(N_SENSORS); i++) cnt_q[i] <= '0;
        end else begin
            sync1_q      <= s_raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            rise_q       <= rise_d;
            trip_valid_q <= trip_valid_d;
            trip_id_q    <= trip_id_d;
            multi_q      <= multi_d;
            order_err_q  <= order_err_d;
            for (int i = 0; i < int'(N_SENSORS); i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign s_level    = level_q;
    assign s_rise     = rise_q;
    assign trip_valid = trip_valid_q;
    assign trip_id    = trip_id_q;
    assign multi_trip = multi_q;
    assign order_err  = order_err_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner with DB_CYCLES=4; expected trips are queued at stimulus time.
module tb_sensor_conditioner;

    localparam int unsigned N  = 6;
    localparam int unsigned DB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] s_raw;
    logic [N-1:0] s_level, s_rise;
    logic         trip_valid, multi_trip, order_err;
    logic [2:0]   trip_id;

    sensor_conditioner #(.N_SENSORS(N), .DB_CYCLES(DB), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .s_raw(s_raw), .s_level(s_level), .s_rise(s_rise),
        .trip_valid(trip_valid), .trip_id(trip_id), .multi_trip(multi_trip), .order_err(order_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] id;
        logic       multi;
        logic       oerr;
    } trip_t;

    trip_t exp_q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    int    rise_cnt = 0;
    int    exp_rises = 0;
    int    model_last = 0;
    int    t0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_level"}, 32'(s_level), 0);
        check_eq({tag, "_rise"}, 32'(s_rise), 0);
        check_eq({tag, "_valid"}, 32'(trip_valid), 0);
        check_eq({tag, "_id"}, 32'(trip_id), 0);
        check_eq({tag, "_multi"}, 32'(multi_trip), 0);
        check_eq({tag, "_oerr"}, 32'(order_err), 0);
    endtask

    // Reference model of one trip event caused by the sensors in mask rising together
    task automatic push_exp(input logic [N-1:0] mask, input int start);
        trip_t e;
        int    id = 0;
        bit    bad;
        for (int i = N - 1; i >= 0; i--) if (mask[i]) id = i + 1;
        e.cyc   = start + int'(DB) + 3;
        e.id    = 3'(id);
        e.multi = ($countones(mask) > 1);
        bad = e.multi;
        if (model_last != 0 && id != (model_last % N) + 1 && model_last != (id % N) + 1) bad = 1'b1;
`ifdef SENSOR_ORDER_CHECK_EN
        e.oerr = bad;
`else
        e.oerr = 1'b0;
`endif
        model_last = id;
        exp_rises += $countones(mask);
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [N-1:0] mask, input int hold, input int gap);
        step();
        s_raw = s_raw | mask;
        push_exp(mask, cyc);
        repeat (hold) step();
        s_raw = s_raw & ~mask;
        repeat (gap) step();
    endtask

    task automatic do_reset(input string tag);
        step();
        rst = 1'b1;
        model_last = 0;
        @(negedge clk);
        check_zero(tag);
        step();
        rst = 1'b0;
    endtask

    // Monitor: every trip pulse must match the head of the scoreboard at the right cycle
    always @(negedge clk) begin
        trip_t e;
        if (!rst) begin
            rise_cnt += $countones(s_rise);
            if (trip_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("trip_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("trip_cycle", cyc, e.cyc);
                    check_eq("trip_id", 32'(trip_id), 32'(e.id));
                    check_eq("multi_trip", 32'(multi_trip), 32'(e.multi));
                    check_eq("order_err", 32'(order_err), 32'(e.oerr));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                check_eq("trip_missing", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        s_raw = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        step();
        rst = 1'b0;
        repeat (3) step();

        // Clean press on S3 with exact latency probes
        step();
        s_raw[2] = 1'b1;
        t0 = cyc;
        push_exp(6'b000100, t0);
        at_cycle(t0 + int'(DB) + 1);
        check_eq("press_level_early", 32'(s_level), 0);
        at_cycle(t0 + int'(DB) + 2);
        check_eq("press_level", 32'(s_level), 32'(6'b000100));
        check_eq("press_rise", 32'(s_rise), 32'(6'b000100));
        at_cycle(t0 + int'(DB) + 3);
        check_eq("press_rise_width", 32'(s_rise), 0);
        at_cycle(t0 + 15);
        check_eq("trip_id_hold", 32'(trip_id), 3);
        while (cyc < t0 + 20) step();
        s_raw[2] = 1'b0;
        repeat (12) step();
        check_eq("release_level", 32'(s_level), 0);

        // Glitches shorter than the debounce window
        step();
        s_raw[0] = 1'b1;
        repeat (3) step();
        s_raw[0] = 1'b0;
        step();
        s_raw[0] = 1'b1;
        repeat (3) step();
        s_raw[0] = 1'b0;
        repeat (12) step();
        check_eq("glitch_level", 32'(s_level), 0);

        // Simultaneous rise, then release and retrip on S1
        press(6'b010010, 10, 12);
        press(6'b000001, 10, 10);
        press(6'b000001, 10, 12);

        // Sequence checking: 1,2,3,6 then wrap 6->1, then repeat 2,2
        do_reset("reset_seq");
        press(6'b000001, 8, 10);
        press(6'b000010, 8, 10);
        press(6'b000100, 8, 10);
        press(6'b100000, 8, 10);
        press(6'b000001, 8, 10);
        press(6'b000010, 8, 10);
        press(6'b000010, 8, 10);

        // Reset during a debounce in progress; S4 stays high across the reset
        step();
        s_raw[3] = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        model_last = 0;
        @(negedge clk);
        check_zero("reset_mid");
        step();
        rst = 1'b0;
        push_exp(6'b001000, cyc);
        repeat (12) step();
        s_raw[3] = 1'b0;
        repeat (12) step();

        // Back-to-back rises on S5 and S6 in consecutive cycles
        step();
        s_raw[4] = 1'b1;
        push_exp(6'b010000, cyc);
        step();
        s_raw[5] = 1'b1;
        push_exp(6'b100000, cyc);
        repeat (10) step();
        s_raw = '0;
        repeat (14) step();

        @(negedge clk);
        check_eq("queue_drained", 32'(exp_q.size()), 0);
        check_eq("rise_count", 32'(rise_cnt), 32'(exp_rises));
        check_eq("final_level", 32'(s_level), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
